// File: rtl/qam_cluster_packer_pkg.sv
// Shared definitions for the QAM cluster packer: FSM encoding, QAM orders, clog2.
package qam_cluster_packer_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int BPS_QPSK  = 2;
  localparam int BPS_QAM16 = 4;
  localparam int BPS_QAM64 = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qam_cluster_packer.sv
// Byte-to-cluster gearbox: packs DIN_W-bit beats into BPS*N-bit clusters for the QAM mapper.
// state    | meaning
// ST_RUN   | accepting beats, emitting full clusters
// ST_FLUSH | frame ended; drain remaining bits, last cluster zero-padded
module qam_cluster_packer
  import qam_cluster_packer_pkg::*;
#(
  parameter int N     = 16,
  parameter int BPS   = BPS_QAM64,
  parameter int DIN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIN_W-1:0]              in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [BPS*N-1:0]              out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [clog2(BPS*N+1)-1:0]     out_pad,
  input  logic                          out_ready
);

  localparam int OUT_W = BPS * N;
  localparam int ACC_W = OUT_W + DIN_W;
  localparam int CNT_W = clog2(ACC_W + 1);
  localparam int PAD_W = clog2(OUT_W + 1);

  if (DIN_W > BPS * N || BPS < 1) begin : g_bad_params
    $error("qam_cluster_packer: DIN_W must not exceed BPS*N and BPS must be at least 1");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_base;
  logic [ACC_W-1:0]  acc_ins;
  logic              out_free;
  logic              accept;
  logic              load_full;
  logic              load_last;
  logic              cnt_ge;
  logic              cnt_gt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (accept && in_last) state_nxt = ST_FLUSH;
      ST_FLUSH: if (load_last || cnt == '0) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    out_free  = !out_valid || out_ready;
    cnt_ge    = cnt >= CNT_W'(OUT_W);
    cnt_gt    = cnt >  CNT_W'(OUT_W);
    // out_ready reaches in_ready combinationally so a load and an accept share a cycle
    in_ready  = (state == ST_RUN) && (!cnt_ge || out_free);
    accept    = in_valid && in_ready;
    load_full = out_free && ((state == ST_RUN) ? cnt_ge : cnt_gt);
    load_last = out_free && (state == ST_FLUSH) && (cnt != '0) && !cnt_gt;

    cnt_base = cnt;
    if (load_full)      cnt_base = cnt - CNT_W'(OUT_W);
    else if (load_last) cnt_base = '0;

    acc_ins = '0;
    if (accept) acc_ins = ACC_W'(in_data) << cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pad   <= '0;
    end else begin
      // a beat accepted alongside a load lands after the shift, at cnt-OUT_W
      if (load_full || load_last) acc <= (acc >> OUT_W) | acc_ins;
      else                        acc <= acc | acc_ins;
      cnt <= cnt_base + (accept ? CNT_W'(DIN_W) : '0);

      if (load_full || load_last) begin
        out_data  <= acc[OUT_W-1:0];
        out_valid <= 1'b1;
        out_last  <= load_last;
        out_pad   <= load_last ? PAD_W'(CNT_W'(OUT_W) - cnt) : '0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_cluster_packer.sv
// Scoreboard bench for qam_cluster_packer: QAM64/8-bit instance plus a QAM16/5-bit instance.
module tb_qam_cluster_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [7:0]  in_data_a = '0;
  logic        in_valid_a = 1'b0, in_last_a = 1'b0, in_ready_a;
  logic [95:0] out_data_a;
  logic        out_valid_a, out_last_a;
  logic [6:0]  out_pad_a;
  logic        out_ready_a = 1'b0;

  logic [4:0]  in_data_b = '0;
  logic        in_valid_b = 1'b0, in_last_b = 1'b0, in_ready_b;
  logic [63:0] out_data_b;
  logic        out_valid_b, out_last_b;
  logic [6:0]  out_pad_b;
  logic        out_ready_b = 1'b0;

  qam_cluster_packer u_a (
    .clk(clk), .rst(rst),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_last(in_last_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a), .out_pad(out_pad_a),
    .out_ready(out_ready_a)
  );

  qam_cluster_packer #(.N(16), .BPS(4), .DIN_W(5)) u_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_last(in_last_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b), .out_pad(out_pad_b),
    .out_ready(out_ready_b)
  );

  typedef struct {
    logic [95:0] data;
    logic        last;
    logic [6:0]  pad;
  } exp_t;

  bit   bq[2][$];
  exp_t exq[2][$];
  int   compared = 0;
  int   mismatched = 0;
  int   acc_a = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a bit-serial FIFO chopped into clusters of ow bits
  function automatic void emit(input int w, input int n, input bit last, input int ow);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i] = bq[w].pop_front();
    e.last = last;
    e.pad  = 7'(ow - n);
    exq[w].push_back(e);
  endfunction

  function automatic void push_beat(input int w, input logic [7:0] d, input bit l);
    int dw = (w == 1) ? 5 : 8;
    int ow = (w == 1) ? 64 : 96;
    for (int i = 0; i < dw; i++) bq[w].push_back(d[i]);
    if (l) begin
      while (bq[w].size() > ow) emit(w, ow, 1'b0, ow);
      emit(w, bq[w].size(), 1'b1, ow);
    end else begin
      while (bq[w].size() >= ow) emit(w, ow, 1'b0, ow);
    end
  endfunction

  task automatic compare_out(input int w, input logic [95:0] d, input logic l, input logic [6:0] p);
    exp_t e;
    if (exq[w].size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL out_unexpected[%0d]: got cluster %0h expected none", w, d);
    end else begin
      e = exq[w].pop_front();
      check($sformatf("out_data[%0d]", w), d, e.data);
      check($sformatf("out_last[%0d]", w), 96'(l), 96'(e.last));
      check($sformatf("out_pad[%0d]", w), 96'(p), 96'(e.pad));
    end
  endtask

  bit          hold_a = 0, hold_b = 0;
  logic [95:0] hd_a, hd_b;
  logic [8:0]  hc_a, hc_b;

  always @(negedge clk) begin
    if (rst) hold_a = 0;
    else begin
      if (hold_a) begin
        check("hold_data_a", out_data_a, hd_a);
        check("hold_ctl_a", 96'({out_valid_a, out_last_a, out_pad_a}), 96'(hc_a));
      end
      hold_a = out_valid_a && !out_ready_a;
      hd_a   = out_data_a;
      hc_a   = {out_valid_a, out_last_a, out_pad_a};
      if (out_valid_a && out_ready_a) compare_out(0, out_data_a, out_last_a, out_pad_a);
    end
  end

  always @(negedge clk) begin
    if (rst) hold_b = 0;
    else begin
      if (hold_b) begin
        check("hold_data_b", 96'(out_data_b), 96'(hd_b));
        check("hold_ctl_b", 96'({out_valid_b, out_last_b, out_pad_b}), 96'(hc_b));
      end
      hold_b = out_valid_b && !out_ready_b;
      hd_b   = 96'(out_data_b);
      hc_b   = {out_valid_b, out_last_b, out_pad_b};
      if (out_valid_b && out_ready_b) compare_out(1, 96'(out_data_b), out_last_b, out_pad_b);
    end
  end

  bit   rr_a = 0, rr_b = 0;
  logic rf_a = 1'b1, rf_b = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready_a = rr_a ? ($urandom_range(0, 3) != 0) : rf_a;
    out_ready_b = rr_b ? ($urandom_range(0, 3) != 0) : rf_b;
  end

  always @(posedge clk) cyc++;

  bit mon4 = 0;
  int lows = 0, pulses = 0, badgap = 0, last_cyc = 0;
  always @(negedge clk) begin
    if (mon4) begin
      if (!in_ready_a) lows++;
      if (out_valid_a) begin
        if (pulses > 0 && cyc - last_cyc != 12) badgap++;
        pulses++;
        last_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_data_a  = 8'($urandom);
    in_last_a  = 1'($urandom);
    in_data_b  = 5'($urandom);
    in_last_b  = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic l);
    int t = 0;
    in_data_a = d; in_last_a = l; in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && t < 300) begin t++; @(negedge clk); end
    if (!in_ready_a) begin
      compared++; mismatched++;
      $display("FAIL send_a_timeout: in_ready got 0 expected 1");
      in_valid_a = 1'b0;
      return;
    end
    @(posedge clk);
    push_beat(0, d, l);
    acc_a++;
    #1;
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] d, input logic l);
    int t = 0;
    in_data_b = d; in_last_b = l; in_valid_b = 1'b1;
    @(negedge clk);
    while (!in_ready_b && t < 300) begin t++; @(negedge clk); end
    if (!in_ready_b) begin
      compared++; mismatched++;
      $display("FAIL send_b_timeout: in_ready got 0 expected 1");
      in_valid_b = 1'b0;
      return;
    end
    @(posedge clk);
    push_beat(1, {3'b000, d}, l);
    #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input int w);
    int t = 0;
    while (exq[w].size() != 0 && t < 2000) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("drain[%0d]", w), 96'(exq[w].size()), 96'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, expected done", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t, extra, len;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", 96'(out_valid_a), 96'(0));
    check("rst_data_a", out_data_a, 96'(0));
    check("rst_last_pad_a", 96'({out_last_a, out_pad_a}), 96'(0));
    check("rst_ready_a", 96'(in_ready_a), 96'(1));
    check("rst_valid_b", 96'({out_valid_b, out_last_b, out_pad_b}), 96'(0));
    check("rst_data_b", 96'(out_data_b), 96'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Test 1: counting bytes, latency and bit order
    for (int i = 0; i < 12; i++) send_a(8'(i), 1'b0);
    @(negedge clk);
    check("t1_valid_before", 96'(out_valid_a), 96'(0));
    @(negedge clk);
    check("t1_valid", 96'(out_valid_a), 96'(1));
    check("t1_data", out_data_a, 96'h0B0A09080706050403020100);
    check("t1_last_pad", 96'({out_last_a, out_pad_a}), 96'(0));
    drain(0);

    // Test 2: short frame, flush with padding
    for (int i = 0; i < 5; i++) send_a(8'hFF, i == 4);
    @(negedge clk);
    check("t2_ready_flush", 96'(in_ready_a), 96'(0));
    @(negedge clk);
    check("t2_valid", 96'(out_valid_a), 96'(1));
    check("t2_data", out_data_a, 96'h00000000000000FFFFFFFFFF);
    check("t2_last", 96'(out_last_a), 96'(1));
    check("t2_pad", 96'(out_pad_a), 96'(56));
    check("t2_ready_after", 96'(in_ready_a), 96'(1));
    drain(0);

    // Test 3: backpressure with two clusters buffered
    rf_a = 1'b0;
    idle(2);
    acc_a = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) send_a(8'($urandom), 1'b0);
      end
      begin
        t = 0;
        while (acc_a < 24 && t < 500) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        check("t3_ready_low", 96'(in_ready_a), 96'(0));
        check("t3_accepted", 96'(acc_a), 96'(24));
        rf_a = 1'b1;
      end
    join
    for (int i = 0; i < 6; i++) send_a(8'($urandom), i == 5);
    drain(0);

    // Test 4: back-to-back full throughput
    mon4 = 1;
    for (int i = 0; i < 120; i++) send_a(8'($urandom), 1'b0);
    idle(3);
    mon4 = 0;
    check("t4_ready_lows", 96'(lows), 96'(0));
    check("t4_pulses", 96'(pulses), 96'(10));
    check("t4_gap", 96'(badgap), 96'(0));
    drain(0);

    // Test 5: last on an exact cluster boundary
    for (int i = 0; i < 12; i++) send_a(8'($urandom), i == 11);
    t = 0;
    @(negedge clk);
    while (!out_valid_a && t < 50) begin @(negedge clk); t++; end
    check("t5_valid", 96'(out_valid_a), 96'(1));
    check("t5_last", 96'(out_last_a), 96'(1));
    check("t5_pad", 96'(out_pad_a), 96'(0));
    extra = 0;
    repeat (5) begin @(negedge clk); if (out_valid_a) extra++; end
    check("t5_no_empty", 96'(extra), 96'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) send_a(8'($urandom), i == 11);
    drain(0);

    // Test 6: reset mid-frame with a stalled cluster
    rf_a = 1'b0;
    idle(2);
    for (int i = 0; i < 12; i++) send_a(8'($urandom), 1'b0);
    idle(3);
    for (int i = 0; i < 7; i++) send_a(8'($urandom), 1'b0);
    rst = 1'b1;
    bq[0].delete(); exq[0].delete();
    bq[1].delete(); exq[1].delete();
    @(posedge clk);
    @(negedge clk);
    check("t6_valid", 96'(out_valid_a), 96'(0));
    check("t6_data", out_data_a, 96'(0));
    check("t6_last_pad", 96'({out_last_a, out_pad_a}), 96'(0));
    check("t6_ready", 96'(in_ready_a), 96'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    rf_a = 1'b1;
    idle(2);
    for (int i = 0; i < 12; i++) send_a(8'($urandom), 1'b0);
    drain(0);

    // Random frames, random backpressure and gaps
    rr_a = 1;
    for (int f = 0; f < 15; f++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_a(8'($urandom), i == len - 1);
      end
    end
    rr_a = 0;
    drain(0);

    // Test 7: BPS=4, DIN_W=5 instance, non-dividing width
    rr_b = 1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_b(5'($urandom), i == len - 1);
      end
    end
    rr_b = 0;
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
